// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - RV32I decode constants, control bundle and opcode classifier
package id_ex_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic legal;
        logic uses_rs1;
        logic uses_rs2;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                c.legal = 1'b1; c.reg_write = 1'b1;
            end
            OP_JALR, OP_IMM: begin
                c.legal = 1'b1; c.uses_rs1 = 1'b1; c.reg_write = 1'b1;
            end
            OP_LOAD: begin
                c.legal = 1'b1; c.uses_rs1 = 1'b1; c.reg_write = 1'b1; c.mem_read = 1'b1;
            end
            OP_OP: begin
                c.legal = 1'b1; c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.reg_write = 1'b1;
            end
            OP_BRANCH: begin
                c.legal = 1'b1; c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1;
            end
            OP_STORE: begin
                c.legal = 1'b1; c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.mem_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// rtl/id_ex_stage_imm_gen.sv - combinational RV32I immediate generator
module id_ex_stage_imm_gen
    import id_ex_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_JALR, OP_LOAD, OP_IMM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - RV32I decode, load-use hazard detect and ID/EX pipeline register
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int REGS_WIDTH = REG_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_en,
    input  logic                  if_id_valid,
    input  logic [31:0]           if_id_pc,
    input  logic [31:0]           if_id_instr,
    output logic [REGS_WIDTH-1:0] rs1_address,
    output logic [REGS_WIDTH-1:0] rs2_address,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  ex_flush,
    input  logic [REGS_WIDTH-1:0] mem_rd,
    input  logic                  mem_reg_write,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic [31:0]           ex_pc,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [31:0]           ex_imm,
    output logic [REGS_WIDTH-1:0] ex_rd,
    output logic [2:0]            ex_funct3,
    output logic                  ex_funct7b5,
    output logic [6:0]            ex_opcode,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic [1:0]            ex_fwd_a,
    output logic [1:0]            ex_fwd_b,
    output logic                  ex_illegal
);

    ctrl_t                  ctrl;
    logic [31:0]            imm;
    logic [REGS_WIDTH-1:0]  rd;
    logic                   hit_rs1;
    logic                   hit_rs2;
    logic                   load_bubble;
    logic                   illegal_capture;
    logic [1:0]             fwd_a;
    logic [1:0]             fwd_b;

    assign ctrl        = decode_ctrl(if_id_instr[6:0]);
    assign rd          = if_id_instr[11:7];
    assign rs1_address = if_id_instr[19:15];
    assign rs2_address = if_id_instr[24:20];

    id_ex_stage_imm_gen u_imm_gen (
        .instr (if_id_instr),
        .imm   (imm)
    );

    assign hit_rs1  = ctrl.uses_rs1 && (ex_rd == rs1_address);
    assign hit_rs2  = ctrl.uses_rs2 && (ex_rd == rs2_address);
    assign id_stall = if_id_valid && ex_valid && ex_mem_read && (ex_rd != '0)
                      && (hit_rs1 || hit_rs2) && !ex_flush;

    assign load_bubble     = ex_flush || id_stall || !if_id_valid || !ctrl.legal;
    assign illegal_capture = if_id_valid && !ex_flush && !ctrl.legal;

    // Select is for the next cycle: today's EX becomes EX/MEM, today's EX/MEM becomes MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [REGS_WIDTH-1:0] src);
        if (!used || src == '0)
            return FWD_REG;
        else if (ex_valid && ex_reg_write && !ex_mem_read && ex_rd == src)
            return FWD_EXMEM;
        else if (mem_reg_write && mem_rd == src)
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

    assign fwd_a = fwd_sel(ctrl.uses_rs1, rs1_address);
    assign fwd_b = fwd_sel(ctrl.uses_rs2, rs2_address);

    always_ff @(posedge clk) begin
        if (rst || (cpu_en && load_bubble)) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_funct3    <= '0;
            ex_funct7b5  <= 1'b0;
            ex_opcode    <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_fwd_a     <= FWD_REG;
            ex_fwd_b     <= FWD_REG;
            ex_illegal   <= rst ? 1'b0 : illegal_capture;
        end else if (cpu_en) begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_id_pc;
            ex_rs1_data  <= rs1_data;
            ex_rs2_data  <= rs2_data;
            ex_imm       <= imm;
            ex_rd        <= rd;
            ex_funct3    <= if_id_instr[14:12];
            ex_funct7b5  <= if_id_instr[30];
            ex_opcode    <= if_id_instr[6:0];
            ex_reg_write <= ctrl.reg_write && (rd != '0);
            ex_mem_read  <= ctrl.mem_read;
            ex_mem_write <= ctrl.mem_write;
            ex_fwd_a     <= fwd_a;
            ex_fwd_b     <= fwd_b;
            ex_illegal   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [4:0]  rs1_address;
    logic [4:0]  rs2_address;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ex_flush;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [6:0]  ex_opcode;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_fwd_a;
    logic [1:0]  ex_fwd_b;
    logic        ex_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .rs1_address(rs1_address), .rs2_address(rs2_address),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_flush(ex_flush), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_opcode(ex_opcode), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .ex_illegal(ex_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
        if_id_valid = 1'b1;
        if_id_pc    = pc;
        if_id_instr = instr;
    endtask

    initial begin
        rst = 1'b1; cpu_en = 1'b1; if_id_valid = 1'b0; if_id_pc = '0; if_id_instr = '0;
        rs1_data = 32'h0000_1000; rs2_data = 32'h0000_2000;
        ex_flush = 1'b0; mem_rd = '0; mem_reg_write = 1'b0;

        // reset
        step(); step();
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_pc", ex_pc, 32'd0);
        check("rst_imm", ex_imm, 32'd0);
        check("rst_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal}, 32'd0);
        check("rst_fwd", {ex_fwd_a, ex_fwd_b}, 32'd0);
        check("rst_stall", 32'(id_stall), 32'd0);
        rst = 1'b0;

        // load-use: lw x5,0(x1) ; add x6,x5,x2
        drive(32'h100, i_type(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
        step();
        check("lw_valid", 32'(ex_valid), 32'd1);
        check("lw_mem_read", 32'(ex_mem_read), 32'd1);
        check("lw_rd", 32'(ex_rd), 32'd5);
        check("lw_rs1_data", ex_rs1_data, 32'h1000);
        check("lw_pc", ex_pc, 32'h100);
        drive(32'h104, r_type(7'd0, 5'd2, 5'd5, 3'b000, 5'd6));
        #1;
        check("add_rs1_addr", 32'(rs1_address), 32'd5);
        check("add_rs2_addr", 32'(rs2_address), 32'd2);
        check("lu_stall", 32'(id_stall), 32'd1);
        step();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_rd", 32'(ex_rd), 32'd0);
        mem_rd = 5'd5; mem_reg_write = 1'b1;
        #1;
        check("lu_stall_clear", 32'(id_stall), 32'd0);
        step();
        check("retry_valid", 32'(ex_valid), 32'd1);
        check("retry_rd", 32'(ex_rd), 32'd6);
        check("retry_pc", ex_pc, 32'h104);
        check("retry_fwd_a", 32'(ex_fwd_a), 32'd2);
        check("retry_fwd_b", 32'(ex_fwd_b), 32'd0);

        // EX/MEM forwarding beats MEM/WB
        mem_rd = '0; mem_reg_write = 1'b0;
        drive(32'h108, r_type(7'd0, 5'd2, 5'd1, 3'b000, 5'd5));
        step();
        check("add5_reg_write", 32'(ex_reg_write), 32'd1);
        check("add5_fwd_a", 32'(ex_fwd_a), 32'd0);
        drive(32'h10c, r_type(7'd0, 5'd5, 5'd5, 3'b000, 5'd6));
        mem_rd = 5'd5; mem_reg_write = 1'b1;
        #1;
        check("add6_stall", 32'(id_stall), 32'd0);
        step();
        check("add6_fwd_a", 32'(ex_fwd_a), 32'd1);
        check("add6_fwd_b", 32'(ex_fwd_b), 32'd1);
        drive(32'h110, r_type(7'b0100000, 5'd6, 5'd5, 3'b000, 5'd7));
        step();
        check("sub7_fwd_a", 32'(ex_fwd_a), 32'd2);
        check("sub7_fwd_b", 32'(ex_fwd_b), 32'd1);
        check("sub7_funct7b5", 32'(ex_funct7b5), 32'd1);

        // load-use with flush in the same cycle
        mem_rd = '0; mem_reg_write = 1'b0;
        drive(32'h114, i_type(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
        step();
        drive(32'h118, r_type(7'd0, 5'd2, 5'd5, 3'b000, 5'd6));
        ex_flush = 1'b1;
        #1;
        check("flush_stall", 32'(id_stall), 32'd0);
        step();
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_rs1_data", ex_rs1_data, 32'd0);
        check("flush_illegal", 32'(ex_illegal), 32'd0);
        ex_flush = 1'b0;

        // cpu_en hold, then x0 destination
        drive(32'h200, i_type(12'd7, 5'd0, 3'b000, 5'd3, 7'b0010011));
        step();
        check("addi3_rd", 32'(ex_rd), 32'd3);
        check("addi3_imm", ex_imm, 32'd7);
        cpu_en = 1'b0;
        drive(32'h204, r_type(7'd0, 5'd2, 5'd1, 3'b000, 5'd9));
        step();
        check("hold_rd", 32'(ex_rd), 32'd3);
        check("hold_imm", ex_imm, 32'd7);
        check("hold_pc", ex_pc, 32'h200);
        cpu_en = 1'b1;
        mem_rd = 5'd0; mem_reg_write = 1'b1;
        drive(32'h208, i_type(12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011));
        step();
        check("x0_valid", 32'(ex_valid), 32'd1);
        check("x0_reg_write", 32'(ex_reg_write), 32'd0);
        check("x0_fwd_a", 32'(ex_fwd_a), 32'd0);
        mem_reg_write = 1'b0;

        // immediate formats
        drive(32'h20c, i_type(12'hfff, 5'd1, 3'b000, 5'd3, 7'b0010011));
        step();
        check("imm_i_neg", ex_imm, 32'hffff_ffff);
        drive(32'h210, {7'h7f, 5'd2, 5'd1, 3'b010, 5'h1c, 7'b0100011});
        step();
        check("imm_s_neg", ex_imm, 32'hffff_fffc);
        check("sw_ctrl", {ex_mem_write, ex_reg_write}, 32'b10);
        drive(32'h214, {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b0100, 1'b0, 7'b1100011});
        step();
        check("imm_b", ex_imm, 32'd8);
        drive(32'h218, {1'b0, 10'b0000001000, 1'b0, 8'd0, 5'd1, 7'b1101111});
        step();
        check("imm_j", ex_imm, 32'd16);

        // unknown opcode, then lui
        drive(32'h21c, 32'h0000_007f);
        step();
        check("ill_valid", 32'(ex_valid), 32'd0);
        check("ill_flag", 32'(ex_illegal), 32'd1);
        drive(32'h220, {20'hABCDE, 5'd3, 7'b0110111});
        step();
        check("lui_imm", ex_imm, 32'hABCD_E000);
        check("lui_illegal", 32'(ex_illegal), 32'd0);
        check("lui_valid", 32'(ex_valid), 32'd1);

        // invalid IF/ID slot
        if_id_valid = 1'b0;
        step();
        check("nop_valid", 32'(ex_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
